serial_word_receiver: RTL and testbench



---
 rtl/serial_word_receiver_pkg.sv | 14 +
 rtl/serial_word_receiver_holder.sv | 47 ++++
 rtl/serial_word_receiver.sv | 102 ++++++++++
 tb/tb_serial_word_receiver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_receiver_pkg.sv
// Shared types and helpers for the serial word receiver.
package serial_word_receiver_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    // Wide enough to hold a bit count of 0..width inclusive.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_word_receiver_holder.sv
// Output word register with valid/ready handshake and sticky overrun flag.
module sr_word_holder #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             complete,
    input  logic [WIDTH-1:0] word_in,
    input  logic             out_ready,
    input  logic             clear_overrun,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             overrun
);

    logic transfer;
    logic accept;
    logic drop;

    assign transfer = out_valid & out_ready;
    assign accept   = complete & (~out_valid | out_ready);
    assign drop     = complete & out_valid & ~out_ready;

    // A drop outranks a clear so that a lost word is never silently forgotten.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (enable) begin
            if (accept) begin
                data_out  <= word_in;
                out_valid <= 1'b1;
            end else if (transfer) begin
                out_valid <= 1'b0;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_word_receiver.sv
// Framed serial-to-parallel receiver: frame FSM, bit counter and shift register,
// with completed words handed to sr_word_holder.
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start_in,
    input  logic             bit_valid,
    input  logic             serial_in,
    input  logic             out_ready,
    input  logic             clear_overrun,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             overrun,
    output logic             busy
);

    localparam int             CW   = count_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    rx_state_t        state, state_next;
    logic [CW-1:0]    count, count_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_bit;
    logic             complete;

    assign shifted   = MSB_FIRST ? {shreg[WIDTH-2:0], serial_in}
                                 : {serial_in, shreg[WIDTH-1:1]};
    assign first_bit = MSB_FIRST ? {{(WIDTH-1){1'b0}}, serial_in}
                                 : {serial_in, {(WIDTH-1){1'b0}}};

    // Completion beats a coincident start: the finishing bit closes the current
    // word and start_in opens the next frame, whose bits begin next cycle.
    always_comb begin
        state_next = state;
        count_next = count;
        shreg_next = shreg;
        complete   = 1'b0;
        if (enable) begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        state_next = SHIFT;
                        count_next = bit_valid ? CW'(1) : '0;
                        shreg_next = bit_valid ? first_bit : '0;
                    end
                end
                SHIFT: begin
                    if (bit_valid && count == LAST) begin
                        complete   = 1'b1;
                        state_next = start_in ? SHIFT : IDLE;
                        count_next = '0;
                        shreg_next = '0;
                    end else if (start_in) begin
                        count_next = bit_valid ? CW'(1) : '0;
                        shreg_next = bit_valid ? first_bit : '0;
                    end else if (bit_valid) begin
                        count_next = count + CW'(1);
                        shreg_next = shifted;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            shreg <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            shreg <= shreg_next;
        end
    end

    assign busy = (state == SHIFT);

    sr_word_holder #(
        .WIDTH (WIDTH)
    ) u_holder (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .complete      (complete),
        .word_in       (shifted),
        .out_ready     (out_ready),
        .clear_overrun (clear_overrun),
        .data_out      (data_out),
        .out_valid     (out_valid),
        .overrun       (overrun)
    );

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench: an MSB-first and an LSB-first receiver share one stimulus
// stream; completed words are checked against a per-instance expected queue.
module tb_serial_word_receiver;

    typedef struct {
        logic       start;
        logic       bv;
        logic       sin;
        logic       rdy;
        logic       en;
        logic       exp_valid;
        logic       exp_busy;
        logic       push;
        logic [5:0] word;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       start_in;
    logic       bit_valid;
    logic       serial_in;
    logic       out_ready;
    logic       clear_overrun;
    logic [5:0] data_msb, data_lsb;
    logic       valid_msb, valid_lsb;
    logic       overrun_msb, overrun_lsb;
    logic       busy_msb, busy_lsb;

    int         n_compared   = 0;
    int         n_mismatched = 0;
    logic [5:0] exp_msb_q[$];
    logic [5:0] exp_lsb_q[$];
    vec_t       vecs[9];

    always #5 clk = ~clk;

    serial_word_receiver #(.WIDTH(6), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .enable(enable), .start_in(start_in),
        .bit_valid(bit_valid), .serial_in(serial_in), .out_ready(out_ready),
        .clear_overrun(clear_overrun), .data_out(data_msb), .out_valid(valid_msb),
        .overrun(overrun_msb), .busy(busy_msb)
    );

    serial_word_receiver #(.WIDTH(6), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .enable(enable), .start_in(start_in),
        .bit_valid(bit_valid), .serial_in(serial_in), .out_ready(out_ready),
        .clear_overrun(clear_overrun), .data_out(data_lsb), .out_valid(valid_lsb),
        .overrun(overrun_lsb), .busy(busy_lsb)
    );

    function automatic logic [5:0] reverse6(input logic [5:0] w);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = w[5-i];
        return r;
    endfunction

    task automatic checkOutput(input string name, input int got, input int exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Words are written in send order: bit 5 goes on the wire first.
    task automatic pushExpected(input logic [5:0] word);
        exp_msb_q.push_back(word);
        exp_lsb_q.push_back(reverse6(word));
    endtask

    task automatic applyStimulus(input logic s, input logic bv, input logic sin,
                                 input logic rdy, input logic clr, input logic en);
        logic pre_rst, pre_vm, pre_vl;
        @(negedge clk);
        start_in      = s;
        bit_valid     = bv;
        serial_in     = sin;
        out_ready     = rdy;
        clear_overrun = clr;
        enable        = en;
        pre_rst = reset;
        pre_vm  = valid_msb;
        pre_vl  = valid_lsb;
        @(posedge clk);
        #1;
        if (!pre_rst && en && valid_msb && (!pre_vm || rdy)) begin
            if (exp_msb_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected msb word: got %0d, expected none", data_msb);
            end else begin
                checkOutput("msb word", int'(data_msb), int'(exp_msb_q.pop_front()));
            end
        end
        if (!pre_rst && en && valid_lsb && (!pre_vl || rdy)) begin
            if (exp_lsb_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected lsb word: got %0d, expected none", data_lsb);
            end else begin
                checkOutput("lsb word", int'(data_lsb), int'(exp_lsb_q.pop_front()));
            end
        end
    endtask

    task automatic sendFrame(input logic [5:0] bits, input logic with_start,
                             input logic start_last, input logic rdy_last,
                             input logic clr_last, input logic accept);
        for (int i = 0; i < 6; i++) begin
            if (i == 5 && accept) pushExpected(bits);
            applyStimulus((i == 0 && with_start) || (i == 5 && start_last), 1'b1,
                          bits[5-i], (i == 5) ? rdy_last : 1'b0,
                          (i == 5) ? clr_last : 1'b0, 1'b1);
        end
    endtask

    task automatic consume();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("valid after consume", int'(valid_msb), 0);
    endtask

    initial begin
        reset = 1'b1;
        {enable, start_in, bit_valid, serial_in, out_ready, clear_overrun} = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        checkOutput("reset data", int'(data_msb), 0);
        checkOutput("reset valid", int'(valid_msb), 0);
        checkOutput("reset overrun", int'(overrun_msb), 0);
        checkOutput("reset busy", int'(busy_msb), 0);

        // Basic frame 1,0,0,0,0,0 held unconsumed, then one ready cycle.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd32};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].push) pushExpected(vecs[i].word);
            applyStimulus(vecs[i].start, vecs[i].bv, vecs[i].sin, vecs[i].rdy, 1'b0, vecs[i].en);
            checkOutput($sformatf("vec%0d valid", i), int'(valid_msb), int'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d busy", i), int'(busy_msb), int'(vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d overrun", i), int'(overrun_msb), 0);
        end
        checkOutput("data held after consume", int'(data_msb), 32);

        // Bits 1,0,1,1,0,0: LSB-first instance assembles 13.
        sendFrame(6'b101100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("lsb-first word", int'(data_lsb), 13);
        checkOutput("msb-first word", int'(data_msb), 44);
        consume();

        // Overrun: A=5 left pending, B=42 dropped.
        sendFrame(6'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        sendFrame(6'd42, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("overrun keeps data", int'(data_msb), 5);
        checkOutput("overrun valid", int'(valid_msb), 1);
        checkOutput("overrun set", int'(overrun_msb), 1);
        checkOutput("overrun set lsb", int'(overrun_lsb), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("overrun cleared", int'(overrun_msb), 0);
        // A drop coinciding with clear_overrun leaves the flag set.
        sendFrame(6'd56, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("set beats clear", int'(overrun_msb), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("overrun cleared again", int'(overrun_msb), 0);

        // B=42 completes on the same edge that A=5 is taken.
        sendFrame(6'd42, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("replace data", int'(data_msb), 42);
        checkOutput("replace valid", int'(valid_msb), 1);
        checkOutput("replace no overrun", int'(overrun_msb), 0);
        consume();

        // Restart after 3 bits, then six ones.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("restart busy", int'(busy_msb), 1);
        checkOutput("restart no word", int'(valid_msb), 0);
        sendFrame(6'd63, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("restart word", int'(data_msb), 63);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("restart valid held", int'(valid_msb), 1);

        // Same case with a 4-cycle enable stall; 63 stays pending throughout.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("stall%0d valid", i), int'(valid_msb), 1);
            checkOutput($sformatf("stall%0d data", i), int'(data_msb), 63);
            checkOutput($sformatf("stall%0d busy", i), int'(busy_msb), 1);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        pushExpected(6'd63);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("stall word", int'(data_msb), 63);
        checkOutput("stall busy done", int'(busy_msb), 0);
        consume();

        // Reset mid-word while a word is pending.
        sendFrame(6'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        checkOutput("midreset data", int'(data_msb), 0);
        checkOutput("midreset valid", int'(valid_msb), 0);
        checkOutput("midreset overrun", int'(overrun_msb), 0);
        checkOutput("midreset busy", int'(busy_msb), 0);
        checkOutput("midreset lsb data", int'(data_lsb), 0);
        sendFrame(6'b010101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("post-reset word", int'(data_msb), 21);
        consume();

        // Back-to-back: next start coincides with the completing bit.
        sendFrame(6'd51, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("b2b busy", int'(busy_msb), 1);
        checkOutput("b2b first word", int'(data_msb), 51);
        sendFrame(6'd14, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("b2b second word", int'(data_msb), 14);
        checkOutput("b2b idle", int'(busy_msb), 0);
        consume();

        checkOutput("msb queue drained", exp_msb_q.size(), 0);
        checkOutput("lsb queue drained", exp_lsb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
